// File: rtl/tt_load_drain_seq.sv
// Load-queue drain sequencer: walks the LQ entries of one load instruction,
// issues one read per accepted handshake and frees each entry a cycle later.
module tt_load_drain_seq #(
    parameter int LQ_DEPTH = 8,
    parameter int LQID_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_drain_req,
    input  logic [LQID_W-1:0] i_drain_ref_count,
    input  logic [LQID_W-1:0] i_drain_lqid_start,
    output logic              o_draining,
    output logic              o_lq_rd_valid,
    output logic [LQID_W-1:0] o_lq_rd_lqid,
    output logic              o_lq_rd_last,
    input  logic              i_lq_rd_ready,
    output logic              o_lq_commit,
    output logic [LQID_W-1:0] o_lq_commit_lqid,
    output logic              o_drain_done
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    // One extra bit so a full-queue drain (count field 0) is representable.
    localparam logic [LQID_W:0] FULL_CNT = (LQID_W+1)'(LQ_DEPTH);
    localparam logic [LQID_W:0] ONE_CNT  = (LQID_W+1)'(1);

    state_t              state_q, state_d;
    logic [LQID_W-1:0]   ptr_q, ptr_d;
    logic [LQID_W:0]     remaining_q, remaining_d;
    logic                commit_q, commit_d;
    logic [LQID_W-1:0]   commit_lqid_q, commit_lqid_d;
    logic                xfer;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        xfer          = 1'b0;
        o_draining    = 1'b0;
        o_lq_rd_valid = 1'b0;
        o_lq_rd_lqid  = '0;
        o_lq_rd_last  = 1'b0;
        o_drain_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_drain_req) begin
                    ptr_d       = i_drain_lqid_start;
                    remaining_d = (i_drain_ref_count == '0) ? FULL_CNT
                                                            : {1'b0, i_drain_ref_count};
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                o_draining    = 1'b1;
                o_lq_rd_valid = 1'b1;
                o_lq_rd_lqid  = ptr_q;
                o_lq_rd_last  = (remaining_q == ONE_CNT);
                xfer          = i_lq_rd_ready;
                if (xfer) begin
                    // Power-of-two depth: the pointer wraps by plain overflow.
                    ptr_d       = ptr_q + LQID_W'(1);
                    remaining_d = remaining_q - ONE_CNT;
                    if (remaining_q == ONE_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Extra busy cycle lets the scoreboard absorb the final commit.
                o_draining   = 1'b1;
                o_drain_done = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        commit_d      = xfer;
        commit_lqid_d = xfer ? ptr_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            remaining_q   <= '0;
            commit_q      <= 1'b0;
            commit_lqid_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            remaining_q   <= remaining_d;
            commit_q      <= commit_d;
            commit_lqid_q <= commit_lqid_d;
        end
    end

    assign o_lq_commit      = commit_q;
    assign o_lq_commit_lqid = commit_lqid_q;

endmodule

// File: tb/tb_tt_load_drain_seq.sv
// Self-checking bench for tt_load_drain_seq: queue-based reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_tt_load_drain_seq;

    localparam int LQ_DEPTH = 8;
    localparam int LQID_W   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_drain_req;
    logic [LQID_W-1:0] i_drain_ref_count;
    logic [LQID_W-1:0] i_drain_lqid_start;
    logic              o_draining;
    logic              o_lq_rd_valid;
    logic [LQID_W-1:0] o_lq_rd_lqid;
    logic              o_lq_rd_last;
    logic              i_lq_rd_ready;
    logic              o_lq_commit;
    logic [LQID_W-1:0] o_lq_commit_lqid;
    logic              o_drain_done;

    int checks   = 0;
    int failures = 0;

    tt_load_drain_seq #(
        .LQ_DEPTH(LQ_DEPTH),
        .LQID_W  (LQID_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_drain_req       (i_drain_req),
        .i_drain_ref_count (i_drain_ref_count),
        .i_drain_lqid_start(i_drain_lqid_start),
        .o_draining        (o_draining),
        .o_lq_rd_valid     (o_lq_rd_valid),
        .o_lq_rd_lqid      (o_lq_rd_lqid),
        .o_lq_rd_last      (o_lq_rd_last),
        .i_lq_rd_ready     (i_lq_rd_ready),
        .o_lq_commit       (o_lq_commit),
        .o_lq_commit_lqid  (o_lq_commit_lqid),
        .o_drain_done      (o_drain_done)
    );

    always #5 clk = ~clk;

    // Reference model: the list of entries still to read, plus the
    // one-cycle-delayed commit and done pulses.
    int  mq[$];
    bit  m_commit;
    int  m_commit_id;
    bit  m_done;
    bit  model_on = 1'b0;
    bit  m_busy;
    bit  m_xfer;
    int  m_n;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_commit    = 1'b0;
            m_commit_id = 0;
            m_done      = 1'b0;
            model_on    = 1'b1;
        end else if (model_on) begin
            m_busy      = (mq.size() > 0) || m_done;
            m_xfer      = (mq.size() > 0) && i_lq_rd_ready;
            m_commit    = m_xfer;
            m_commit_id = m_xfer ? mq[0] : 0;
            m_done      = 1'b0;
            if (m_xfer) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
            if (!m_busy && i_drain_req) begin
                m_n = (i_drain_ref_count == 0) ? LQ_DEPTH : int'(i_drain_ref_count);
                for (int k = 0; k < m_n; k++)
                    mq.push_back((int'(i_drain_lqid_start) + k) % LQ_DEPTH);
            end
        end
    end

    function automatic logic [10:0] model_exp();
        logic       v;
        logic [2:0] rid;
        logic [2:0] cid;
        v   = (mq.size() > 0);
        rid = v ? 3'(mq[0]) : 3'd0;
        cid = m_commit ? 3'(m_commit_id) : 3'd0;
        return {v | m_done, v, rid, (mq.size() == 1), m_commit, cid, m_done};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {o_draining, o_lq_rd_valid, o_lq_rd_lqid, o_lq_rd_last,
                o_lq_commit, o_lq_commit_lqid, o_drain_done};
    endfunction

    // Per-cycle comparison and transaction log, both away from the active edge.
    int obs_reads[$];
    int obs_commits[$];
    int obs_last;
    int done_cnt;

    always @(negedge clk) begin
        if (model_on) begin
            logic [10:0] act, exp;
            act = dut_vec();
            exp = model_exp();
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t actual=%b required=%b (drn,vld,lqid,last,cmt,cid,done)",
                         $time, act, exp);
            end
            if (o_lq_rd_valid && i_lq_rd_ready) begin
                obs_reads.push_back(int'(o_lq_rd_lqid));
                if (o_lq_rd_last) obs_last = int'(o_lq_rd_lqid);
            end
            if (o_lq_commit) obs_commits.push_back(int'(o_lq_commit_lqid));
            if (o_drain_done) done_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_seq(input string name, input int act[$], input int exp[$]);
        bit ok;
        ok = (act.size() == exp.size());
        if (ok) for (int i = 0; i < exp.size(); i++) if (act[i] != exp[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%p required=%p", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        obs_reads.delete();
        obs_commits.delete();
        obs_last = -1;
        done_cnt = 0;
    endtask

    task automatic do_req(input int start, input int cnt);
        i_drain_req        = 1'b1;
        i_drain_lqid_start = LQID_W'(start);
        i_drain_ref_count  = LQID_W'(cnt);
        tick();
        i_drain_req        = 1'b0;
    endtask

    // Counts cycles after acceptance until o_drain_done is seen (bounded).
    task automatic wait_done(input int bound, output int k);
        k = 1;
        while (!o_drain_done && k <= bound) begin
            tick();
            k++;
        end
    endtask

    int k;

    initial begin
        reset              = 1'b1;
        i_drain_req        = 1'b0;
        i_drain_ref_count  = '0;
        i_drain_lqid_start = '0;
        i_lq_rd_ready      = 1'b0;
        clear_log();
        repeat (2) tick();
        chk("reset_outputs", int'(dut_vec()), 0);

        // Basic, accepted in the very first cycle out of reset.
        reset         = 1'b0;
        i_lq_rd_ready = 1'b1;
        clear_log();
        do_req(2, 3);
        wait_done(20, k);
        chk("basic_latency", k, 4);
        tick();
        chk_seq("basic_reads", obs_reads, '{2, 3, 4});
        chk_seq("basic_commits", obs_commits, '{2, 3, 4});
        chk("basic_last", obs_last, 4);
        chk("basic_done", done_cnt, 1);

        // Pointer wrap.
        clear_log();
        do_req(6, 4);
        wait_done(20, k);
        tick();
        chk_seq("wrap_reads", obs_reads, '{6, 7, 0, 1});
        chk("wrap_last", obs_last, 1);

        // Full queue (count field 0).
        clear_log();
        do_req(5, 0);
        wait_done(30, k);
        chk("full_latency", k, 9);
        tick();
        chk_seq("full_reads", obs_reads, '{5, 6, 7, 0, 1, 2, 3, 4});
        chk_seq("full_commits", obs_commits, '{5, 6, 7, 0, 1, 2, 3, 4});
        chk("full_done", done_cnt, 1);

        // Backpressure on the first read.
        clear_log();
        i_lq_rd_ready = 1'b0;
        do_req(0, 2);
        for (int s = 0; s < 3; s++) begin
            chk("bp_hold_vld", int'(o_lq_rd_valid), 1);
            chk("bp_hold_lqid", int'(o_lq_rd_lqid), 0);
            chk("bp_no_commit", int'(o_lq_commit), 0);
            tick();
        end
        i_lq_rd_ready = 1'b1;
        wait_done(20, k);
        tick();
        chk_seq("bp_commits", obs_commits, '{0, 1});
        chk("bp_done", done_cnt, 1);

        // Request while busy is ignored; re-presented after DONE it is taken.
        clear_log();
        do_req(5, 2);
        do_req(3, 1);
        wait_done(20, k);
        tick();
        do_req(3, 1);
        wait_done(20, k);
        tick();
        chk_seq("busy_reads", obs_reads, '{5, 6, 3});
        chk("busy_done", done_cnt, 2);

        // Reset after the second transfer aborts the drain.
        clear_log();
        do_req(1, 5);
        tick();
        tick();
        reset         = 1'b1;
        i_lq_rd_ready = 1'b0;
        tick();
        chk("midrst_outputs", int'(dut_vec()), 0);
        reset         = 1'b0;
        i_lq_rd_ready = 1'b1;
        repeat (6) tick();
        chk_seq("midrst_commits", obs_commits, '{1, 2});
        chk("midrst_done", done_cnt, 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            reset              = ($urandom_range(0, 299) == 0);
            i_drain_req        = ($urandom_range(0, 2) == 0);
            i_drain_lqid_start = LQID_W'($urandom_range(0, LQ_DEPTH - 1));
            i_drain_ref_count  = LQID_W'($urandom_range(0, LQ_DEPTH - 1));
            i_lq_rd_ready      = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset         = 1'b0;
        i_drain_req   = 1'b0;
        i_lq_rd_ready = 1'b1;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_load_drain_seq.md
TT_LOAD_DRAIN_SEQ -- requirements
Module: tt_load_drain_seq

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 8, number of load-queue entries (power of two).
REQ-002 SHALL have parameter LQID_W, default 3, log2(LQ_DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_drain_req, input, 1, scoreboard has a load instruction ready to drain.
REQ-006 SHALL have port i_drain_ref_count, input, LQID_W, number of LQ entries to drain; 0 encodes LQ_DEPTH.
REQ-007 SHALL have port i_drain_lqid_start, input, LQID_W, first LQ entry of the instruction.
REQ-008 SHALL have port o_draining, output, 1, sequencer busy; request not accepted while high.
REQ-009 SHALL have port o_lq_rd_valid, output, 1, LQ entry read request to VRF writeback path.
REQ-010 SHALL have port o_lq_rd_lqid, output, LQID_W, LQ entry being read.
REQ-011 SHALL have port o_lq_rd_last, output, 1, current read is final entry of the instruction.
REQ-012 SHALL have port i_lq_rd_ready, input, 1, writeback path accepts read this cycle.
REQ-013 SHALL have port o_lq_commit, output, 1, one-cycle pulse freeing an LQ entry.
REQ-014 SHALL have port o_lq_commit_lqid, output, LQID_W, LQ entry freed.
REQ-015 SHALL have port o_drain_done, output, 1, one-cycle pulse at end of instruction drain.

Function
REQ-016 SHALL implement FSM states IDLE, DRAIN, DONE.
REQ-017 IDLE: o_draining=0, o_lq_rd_valid=0; on i_drain_req=1 SHALL latch ptr=i_drain_lqid_start, remaining=(i_drain_ref_count==0 ? LQ_DEPTH : i_drain_ref_count), next state DRAIN.
REQ-018 Acceptance SHALL occur in the same cycle i_drain_req is seen with o_draining=0; request is single-cycle from the sequencer's view and not re-sampled.
REQ-019 DRAIN: o_draining=1, o_lq_rd_valid=1, o_lq_rd_lqid=ptr, o_lq_rd_last=(remaining==1).
REQ-020 Handshake: transfer when o_lq_rd_valid && i_lq_rd_ready; o_lq_rd_valid, lqid, last SHALL hold stable while i_lq_rd_ready=0.
REQ-021 On transfer: ptr <= ptr+1 modulo LQ_DEPTH (wraps LQ_DEPTH-1 -> 0); remaining <= remaining-1.
REQ-022 On transfer with remaining==1: next state DONE; otherwise stay DRAIN (back-to-back reads at one per cycle when ready held high).
REQ-023 o_lq_commit SHALL pulse exactly one cycle after each transfer, with o_lq_commit_lqid = lqid of that transfer (registered).
REQ-024 DONE: o_draining=1, o_lq_rd_valid=0, o_drain_done=1 for one cycle, next state IDLE; provides one cycle for scoreboard ref_count to settle after final commit before next acceptance.
REQ-025 i_drain_req while o_draining=1 SHALL be ignored with no state change.
REQ-026 remaining counter SHALL be LQID_W+1 bits to represent LQ_DEPTH.
REQ-027 Number of commits per accepted request SHALL equal decoded ref count; o_drain_done SHALL follow last commit in same cycle as that commit pulse.
REQ-028 Minimum request-to-done: N+1 cycles after acceptance for N entries with ready held high; minimum turnaround to next acceptance: N+2 cycles.

Reset
REQ-029 While reset=1 at posedge: state=IDLE, ptr=0, remaining=0, all outputs 0 (o_draining, o_lq_rd_valid, o_lq_rd_lqid, o_lq_rd_last, o_lq_commit, o_lq_commit_lqid, o_drain_done).
REQ-030 Reset asserted mid-DRAIN SHALL abort the drain; no o_lq_commit or o_drain_done pulse in the cycle after reset; pending commit discarded.
REQ-031 First acceptance possible in first cycle after reset deasserts.

Verification
REQ-032 Basic: start=2, count=3, ready=1 -> reads lqid 2,3,4 on consecutive cycles, last on 4; commits 2,3,4 one cycle later each; done with commit 4.
REQ-033 Wrap: start=6, count=4 -> reads 6,7,0,1; last on 1.
REQ-034 Full queue: start=5, count=0 -> 8 reads 5,6,7,0,1,2,3,4, 8 commits, one done.
REQ-035 Backpressure: start=0, count=2, ready low 3 cycles on first read -> lqid 0 held stable, no commit until transfer; total 2 commits.
REQ-036 Busy ignore: second i_drain_req (start=3, count=1) during DRAIN -> ignored; accepted only if re-presented after DONE returns to IDLE.
REQ-037 Reset mid-drain: start=1, count=5, reset after 2nd transfer -> all outputs 0 next cycle, no further commits or done.
